// File: rtl/bridge_target_cmd_sched.sv
// Round-robin scheduler for the target-to-host command channel.
// Loads four parameter words and the cmd semaphore into the target window,
// polls for the host's "ok" status and returns the result (or a timeout)
// to the granted requester.
module bridge_target_cmd_sched #(
    parameter int unsigned NREQ     = 3,
    parameter logic [23:0] TIMEOUT  = 24'd12_000_000,
    parameter int unsigned POLL_GAP = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [16*NREQ-1:0]    req_cmd_i,
    input  logic [128*NREQ-1:0]   req_param_i,
    output logic [NREQ-1:0]       grant_o,
    output logic                  done_o,
    output logic [15:0]           result_o,
    output logic                  timeout_o,
    output logic                  reg_wr_o,
    output logic                  reg_rd_o,
    output logic [7:0]            reg_addr_o,
    output logic [31:0]           reg_wdata_o,
    input  logic [31:0]           reg_rdata_i,
    output logic                  busy_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned TW = 24;

    localparam logic [15:0] CMD_MAGIC  = 16'h636D;
    localparam logic [15:0] OK_MAGIC   = 16'h6F6B;
    localparam logic [7:0]  ADDR_CMD   = 8'h00;
    localparam logic [7:0]  ADDR_PARAM = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WPARAM,
        ST_WCMD,
        ST_POLL_RD,
        ST_POLL_CHK,
        ST_GAP,
        ST_FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         last_q, last_d;
    logic [1:0]            idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [15:0]           cmd_q, cmd_d;
    logic [3:0][31:0]      param_q, param_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic                  done_q, done_d;
    logic [15:0]           result_q, result_d;
    logic                  timeout_q, timeout_d;
    logic                  reg_wr_q, reg_wr_d;
    logic                  reg_rd_q, reg_rd_d;
    logic [7:0]            reg_addr_q, reg_addr_d;
    logic [31:0]           reg_wdata_q, reg_wdata_d;
    logic                  busy_q, busy_d;

    logic                  arb_found;
    logic [IW-1:0]         arb_win;
    int unsigned           arb_pos;
    logic [15:0]           arb_cmd;
    logic [3:0][31:0]      arb_param;

    // Rotating-priority pick: first requester strictly after last_q, plus its payload.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = last_q;
        arb_pos   = 0;
        arb_cmd   = '0;
        arb_param = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            arb_pos = 32'(last_q) + k;
            if (arb_pos >= NREQ) begin
                arb_pos = arb_pos - NREQ;
            end
            if (!arb_found && req_i[IW'(arb_pos)]) begin
                arb_found = 1'b1;
                arb_win   = IW'(arb_pos);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_win == IW'(i)) begin
                arb_cmd   = req_cmd_i[16*i +: 16];
                arb_param = req_param_i[128*i +: 128];
            end
        end
    end

    // Next-state logic; outputs are derived from the state being entered so they register in step with it.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        tcnt_d      = tcnt_q;
        cmd_d       = cmd_q;
        param_d     = param_q;
        grant_d     = grant_q;
        result_d    = result_q;
        timeout_d   = 1'b0;
        done_d      = 1'b0;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        reg_addr_d  = 8'h00;
        reg_wdata_d = '0;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (arb_found) begin
                    grant_d = NREQ'(1) << arb_win;
                    cmd_d   = arb_cmd;
                    param_d = arb_param;
                    last_d  = arb_win;
                    idx_d   = 2'd0;
                    state_d = ST_WPARAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WPARAM: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_WCMD;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_WCMD: begin
                tcnt_d  = '0;
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    state_d = ST_POLL_RD;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_POLL_RD: begin
                state_d = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                if (reg_rdata_i[31:16] == OK_MAGIC) begin
                    result_d  = reg_rdata_i[15:0];
                    timeout_d = 1'b0;
                    state_d   = ST_FINISH;
                end else if (tcnt_q >= TIMEOUT) begin
                    result_d  = 16'hFFFF;
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_FINISH: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Saturating command age, counted from the cycle after the semaphore write.
        if ((state_q == ST_GAP || state_q == ST_POLL_RD || state_q == ST_POLL_CHK) &&
            (tcnt_q != {TW{1'b1}})) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_FINISH);
        reg_rd_d = (state_d == ST_POLL_RD);
        if (state_d == ST_WPARAM) begin
            reg_wr_d    = 1'b1;
            reg_addr_d  = ADDR_PARAM + {4'd0, idx_d, 2'b00};
            reg_wdata_d = param_d[idx_d];
        end else if (state_d == ST_WCMD) begin
            reg_wr_d    = 1'b1;
            reg_addr_d  = ADDR_CMD;
            reg_wdata_d = {CMD_MAGIC, cmd_d};
        end
    end

    // State and output registers; reset drops every strobe at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            last_q      <= IW'(NREQ - 1);
            idx_q       <= 2'd0;
            gap_q       <= '0;
            tcnt_q      <= '0;
            cmd_q       <= '0;
            param_q     <= '0;
            grant_q     <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            tcnt_q      <= tcnt_d;
            cmd_q       <= cmd_d;
            param_q     <= param_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign timeout_o   = timeout_q;
    assign reg_wr_o    = reg_wr_q;
    assign reg_rd_o    = reg_rd_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bridge_target_cmd_sched.sv
// Directed bench for bridge_target_cmd_sched with a small host register model.
module tb_bridge_target_cmd_sched;

    localparam int unsigned NREQ = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [16*NREQ-1:0]  req_cmd = '0;
    logic [128*NREQ-1:0] req_param = '0;
    logic [NREQ-1:0]   grant;
    logic              done;
    logic [15:0]       result;
    logic              timeout;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_addr;
    logic [31:0]       reg_wdata;
    logic [31:0]       reg_rdata = '0;
    logic              busy;

    bridge_target_cmd_sched #(
        .NREQ     (NREQ),
        .TIMEOUT  (24'd100),
        .POLL_GAP (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .req_cmd_i   (req_cmd),
        .req_param_i (req_param),
        .grant_o     (grant),
        .done_o      (done),
        .result_o    (result),
        .timeout_o   (timeout),
        .reg_wr_o    (reg_wr),
        .reg_rd_o    (reg_rd),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Host model: replies ok on poll number reply_poll (0 = never), stale cmd word before that.
    int          reply_poll = 0;
    logic [15:0] reply_code = '0;
    logic [31:0] last_cmd_word = '0;
    int          polls = 0;

    always @(posedge clk) begin
        if (reg_wr && reg_addr == 8'h00) begin
            last_cmd_word <= reg_wdata;
            polls         <= 0;
        end
        if (reg_rd) begin
            polls <= polls + 1;
            if (reply_poll != 0 && polls + 1 >= reply_poll)
                reg_rdata <= {16'h6F6B, reply_code};
            else
                reg_rdata <= last_cmd_word;
        end
    end

    // Bus monitor: write log, done count, strobe exclusivity.
    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          done_n = 0;
    bit          both_seen = 1'b0;

    always @(negedge clk) begin
        if (reg_wr) begin
            wa.push_back(int'(reg_addr));
            wd.push_back(reg_wdata);
            wc.push_back(cyc);
        end
        if (done) done_n <= done_n + 1;
        if (reg_wr && reg_rd) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_done(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] cmd,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3);
        req_cmd[16*i +: 16]    = cmd;
        req_param[128*i +: 128] = {p3, p2, p1, p0};
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          at;
        int          d0;
        int          n;
        bit          hit;
        logic [2:0]  rr_exp [4];

        rr_exp = '{3'd1, 3'd2, 3'd4, 3'd1};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_result",  32'(result), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_wr",      32'(reg_wr), 32'd0);
        check("rst_rd",      32'(reg_rd), 32'd0);
        check("rst_addr",    32'(reg_addr), 32'd0);
        check("rst_wdata",   reg_wdata, 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single request from requester 0, ok on third poll
        set_req(0, 16'h0140, 32'd1, 32'd2, 32'd3, 32'd4);
        reply_poll = 3;
        reply_code = 16'h0000;
        repeat (2) @(negedge clk);
        #1 clear_log();
        @(negedge clk);
        req = 3'b001;
        @(posedge clk); #1;
        check("t1_arb_grant", 32'(grant), 32'd0);
        check("t1_arb_busy",  32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t1_grant_t2",  32'(grant), 32'd1);
        wait_done(200, seen, at);
        check("t1_done_seen", 32'(seen), 32'd1);
        check("t1_result",    32'(result), 32'h0000);
        check("t1_timeout",   32'(timeout), 32'd0);
        check("t1_grant",     32'(grant), 32'd1);
        req = 3'b000;
        @(negedge clk); #1;
        check("t1_nwrites", 32'(wa.size()), 32'd5);
        if (wa.size() == 5) begin
            for (int k = 0; k < 4; k++) begin
                check("t1_paddr", 32'(wa[k]), 32'h20 + 32'(4 * k));
                check("t1_pdata", wd[k], 32'(k + 1));
            end
            check("t1_caddr",   32'(wa[4]), 32'h00);
            check("t1_cdata",   wd[4], 32'h636D_0140);
            check("t1_consec",  32'(wc[4] - wc[0]), 32'd4);
            check("t1_latency", 32'(at - wc[4]), 32'd31);
        end
        check("t1_polls", 32'(polls), 32'd3);

        // Dropped request from requester 2, stale read then result 0x0003
        set_req(2, 16'h0150, 32'h11, 32'h22, 32'h33, 32'h44);
        reply_poll = 2;
        reply_code = 16'h0003;
        repeat (3) @(negedge clk);
        #1 clear_log();
        d0 = done_n;
        @(negedge clk);
        req = 3'b100;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant != '0) begin hit = 1'b1; break; end
        end
        check("t2_grant_seen", 32'(hit), 32'd1);
        check("t2_grant_pre",  32'(grant), 32'd4);
        req = 3'b000;
        wait_done(200, seen, at);
        check("t2_done_seen", 32'(seen), 32'd1);
        check("t2_result",    32'(result), 32'h0003);
        check("t2_timeout",   32'(timeout), 32'd0);
        check("t2_grant",     32'(grant), 32'd4);
        @(negedge clk); #1;
        check("t2_nwrites", 32'(wa.size()), 32'd5);
        if (wa.size() == 5) begin
            check("t2_cdata",   wd[4], 32'h636D_0150);
            check("t2_p3data",  wd[3], 32'h44);
            check("t2_latency", 32'(at - wc[4]), 32'd21);
        end
        check("t2_polls", 32'(polls), 32'd2);
        repeat (30) @(negedge clk);
        #1;
        check("t2_one_done", 32'(done_n - d0), 32'd1);
        check("t2_idle",     32'(busy), 32'd0);

        // Timeout: host never replies
        set_req(1, 16'h0222, 32'h5, 32'h6, 32'h7, 32'h8);
        reply_poll = 0;
        #1 clear_log();
        @(negedge clk);
        req = 3'b010;
        wait_done(300, seen, at);
        check("t3_done_seen", 32'(seen), 32'd1);
        check("t3_timeout",   32'(timeout), 32'd1);
        check("t3_result",    32'(result), 32'hFFFF);
        check("t3_grant",     32'(grant), 32'd2);
        req = 3'b000;
        @(negedge clk); #1;
        if (wa.size() == 5)
            check("t3_latency", 32'(at - wc[4]), 32'd111);
        else
            check("t3_nwrites", 32'(wa.size()), 32'd5);
        check("t3_result_hold", 32'(result), 32'hFFFF);
        check("t3_done_pulse",  32'(done), 32'd0);

        // Reset during GAP, then requester 1 is served again
        set_req(1, 16'h0333, 32'h9, 32'hA, 32'hB, 32'hC);
        reply_poll = 3;
        reply_code = 16'h0000;
        @(negedge clk);
        req = 3'b010;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (reg_wr && reg_addr == 8'h00) begin hit = 1'b1; break; end
        end
        check("t4_wcmd_seen", 32'(hit), 32'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t4_grant",   32'(grant), 32'd0);
        check("t4_busy",    32'(busy), 32'd0);
        check("t4_wr",      32'(reg_wr), 32'd0);
        check("t4_rd",      32'(reg_rd), 32'd0);
        check("t4_done",    32'(done), 32'd0);
        check("t4_addr",    32'(reg_addr), 32'd0);
        check("t4_wdata",   reg_wdata, 32'd0);
        n = wa.size();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t4_no_recovery_wr", 32'(wa.size()), 32'(n));
        wait_done(200, seen, at);
        check("t4_done_seen", 32'(seen), 32'd1);
        check("t4_regrant",   32'(grant), 32'd2);
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Round robin with all three requests held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 16'h0A00, 32'h1, 32'h1, 32'h1, 32'h1);
        set_req(1, 16'h0A01, 32'h2, 32'h2, 32'h2, 32'h2);
        set_req(2, 16'h0A02, 32'h3, 32'h3, 32'h3, 32'h3);
        reply_poll = 1;
        reply_code = 16'h0000;
        #1 d0 = done_n;
        @(negedge clk);
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_done(100, seen, at);
            check("rr_done_seen", 32'(seen), 32'd1);
            check("rr_grant", 32'(grant), 32'(rr_exp[i]));
            if (i == 3) req = 3'b000;
        end
        repeat (40) @(negedge clk);
        #1;
        check("rr_done_count", 32'(done_n - d0), 32'd4);
        check("rr_idle",       32'(busy), 32'd0);

        check("wr_rd_exclusive", 32'(both_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bridge_target_cmd_sched.md
# bridge_target_cmd_sched

Round-robin scheduler that shares the single target-to-host command channel of the bridge command handler between several on-core requesters (soft CPU, slot loader, ready-to-run notifier). It owns the target command register window (offsets 0x00 and 0x20–0x2C): it loads parameter words, writes the `cmd` semaphore and polls for the host's `ok` reply. It returns the 16-bit result code, or a timeout, to the granted requester. It sits between the requesters and the register-file port of the command handler, in the handler's clock domain.

## Interface
- `NREQ`, default 3: number of requesters, 2..8.
- `TIMEOUT`, default 24'd12_000_000: cycles allowed from semaphore write to `ok` reply.
- `POLL_GAP`, default 8: idle cycles between status polls, at least 1.
- `clk` in 1: handler clock. All signals synchronous to it.
- `reset` in 1: asynchronous, active-high.
- `req` in NREQ: per-requester request level, held until that requester's `done`.
- `req_cmd` in 16·NREQ: command word; requester i uses bits [16i+15:16i].
- `req_param` in 128·NREQ: four parameter words; word k of requester i is at [128i+32k+31:128i+32k] and goes to offset 0x20+4k.
- `grant` out NREQ: one-hot, high from arbitration until `done`.
- `done` out 1: one-cycle pulse at completion, qualified by `grant`.
- `result` out 16: result code; valid while `done` is high, holds its value otherwise.
- `timeout` out 1: high with `done` if the host never replied.
- `reg_wr` out 1, `reg_rd` out 1: register-file strobes, never asserted together.
- `reg_addr` out 8: byte offset within the target window.
- `reg_wdata` out 32: write data.
- `reg_rdata` in 32: read data, valid exactly one cycle after `reg_rd`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ARB, WPARAM, WCMD, POLL_RD, POLL_CHK, GAP, FINISH.
- IDLE: if any `req` bit is set, go to ARB.
- ARB: pick the first set `req` bit strictly after `last` (the last granted index), wrapping modulo NREQ. Set `grant` one-hot, latch that requester's cmd and params, set `last` to the winner, clear `idx`, go to WPARAM.
- WPARAM: `reg_wr`=1, `reg_addr`=0x20+4·idx, `reg_wdata`=param[idx]. After idx=3, go to WCMD.
- WCMD: `reg_wr`=1, `reg_addr`=0x00, `reg_wdata`={16'h636D, cmd}. Clear the timeout counter `tcnt`. Go to GAP.
- GAP: wait POLL_GAP cycles, then go to POLL_RD.
- POLL_RD: `reg_rd`=1, `reg_addr`=0x00. Go to POLL_CHK.
- POLL_CHK, evaluated in this order:
  - If `reg_rdata[31:16]`==16'h6F6B: `result`=`reg_rdata[15:0]`, `timeout`=0, go to FINISH.
  - Else if `tcnt`≥TIMEOUT: `result`=16'hFFFF, `timeout`=1, go to FINISH.
  - Else go to GAP.
- `tcnt` is 24 bits and saturating. It increments every cycle from the cycle after WCMD until FINISH.
- FINISH: pulse `done` for one cycle, clear `grant`, go to IDLE. A re-asserted request is arbitrated no earlier than the cycle after IDLE.
- Dropping `req` while granted does not abort the sequence. It runs to FINISH and pulses `done` anyway.
- Any other value in the status word (e.g. 16'h636D still present) counts as "not yet". Only 16'h6F6B completes a command.

## Timing
- Reset values: `grant`=0, `done`=0, `result`=0, `timeout`=0, `reg_wr`=0, `reg_rd`=0, `reg_addr`=0, `reg_wdata`=0, `busy`=0, `last`=NREQ-1 (so requester 0 wins the first arbitration).
- Asserting `reset` mid-sequence returns to IDLE immediately with all strobes low. No recovery write to 0x00 is issued.
- From `req` rising while IDLE, `grant` rises 2 cycles later (IDLE→ARB, registered).
- The five register writes occupy 5 consecutive cycles starting the cycle after ARB.
- Polling period is POLL_GAP+2 cycles.
- When the host replies, `done` rises 1 cycle after the POLL_CHK that sees `ok`.
- All outputs are registered. There are no combinational paths from input to output.
- Requests arriving while `busy` are held, not lost. Simultaneous requests are served in rotating order.

## Test plan
- Single request: req0, cmd 0x0140, params 1/2/3/4. Expect writes 0x20=1, 0x24=2, 0x28=3, 0x2C=4, then 0x00=0x636D0140. Model replies 0x6F6B0000 on the 3rd poll. Expect `done` with `result`=0, `timeout`=0, `grant`=001.
- Round-robin: req0..2 all held high continuously. Expect grant order 0, 1, 2, 0, with exactly one `done` per grant.
- Result code: model replies 0x6F6B0003. Expect `result`=0x0003. A stale 0x636D0140 read before the reply must not complete the command.
- Timeout: TIMEOUT=100 and the host never replies. Expect `done` with `timeout`=1 and `result`=0xFFFF, no earlier than 100 cycles after WCMD.
- Reset mid-poll: assert `reset` during GAP. Expect every output at its reset value within the same cycle and `busy`=0. After release, a new req1 wins (last=NREQ-1 rule gives priority to 0 only if req0 is set).
- Dropped request: deassert req2 after `grant`. Expect the full sequence to complete and a single `done`.
